// File: rtl/filter_mode_controller.sv
// filter_mode_controller
//
// Runtime configuration controller for the VGA filter chain
// (threshold stage -> brightness stage). The three raw user keys are
// synchronized and debounced. Each clean press edits a pending
// configuration. The pending configuration is copied to the active filter
// controls only on frame_start, so a frame never sees a configuration
// change part way through.
//
// Parameters
//   DEBOUNCE_CYCLES : stable cycles needed to accept a key level change (>=1)
//   BRIGHT_LEVELS   : number of brightness levels cycled by KEY3 (>=2)
//   BRIGHT_STEP     : offset added per brightness level
//   RESET_LEVEL     : brightness level after reset (< BRIGHT_LEVELS)
//
// Ports
//   clk           in  1 : pixel clock
//   reset         in  1 : synchronous, active-high
//   key_n         in  3 : raw active-low keys, asynchronous to clk
//                         bit0 = threshold toggle
//                         bit1 = brightness toggle
//                         bit2 = level step
//   frame_start   in  1 : one-cycle pulse at the first pixel of a frame
//   thresh_en     out 1 : active threshold enable
//   bright_en     out 1 : active brightness enable
//   bright_offset out 8 : active brightness offset
//   cfg_dirty     out 1 : pending configuration differs from active
//   cfg_commit    out 1 : pulse when a commit changes the active config
module filter_mode_controller #(
  parameter int DEBOUNCE_CYCLES = 250000,
  parameter int BRIGHT_LEVELS   = 4,
  parameter int BRIGHT_STEP     = 32,
  parameter int RESET_LEVEL     = 1
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [2:0] key_n,
  input  logic       frame_start,
  output logic       thresh_en,
  output logic       bright_en,
  output logic [7:0] bright_offset,
  output logic       cfg_dirty,
  output logic       cfg_commit
);

  localparam int CNT_W = (DEBOUNCE_CYCLES > 2) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam int LVL_W = $clog2(BRIGHT_LEVELS);

  // The wait states leave when the count is about to reach
  // DEBOUNCE_CYCLES-1. Together with the 2-flop synchronizer and the
  // registered event, a press is reported DEBOUNCE_CYCLES+2 cycles after
  // the key falls.
  localparam logic [CNT_W-1:0] CNT_LAST =
    CNT_W'((DEBOUNCE_CYCLES >= 2) ? (DEBOUNCE_CYCLES - 2) : 0);
  localparam logic [LVL_W-1:0] LVL_MAX = LVL_W'(BRIGHT_LEVELS - 1);
  localparam logic [LVL_W-1:0] LVL_RST = LVL_W'(RESET_LEVEL);

  typedef enum logic [1:0] {
    RELEASED,
    PRESS_WAIT,
    PRESSED,
    RELEASE_WAIT
  } key_state_t;

  // The offset is formed at 16 bits, then clamped to the 8-bit range.
  function automatic logic [7:0] sat_offset(input logic [LVL_W-1:0] lvl);
    logic [15:0] prod;
    prod = 16'(lvl) * 16'(BRIGHT_STEP);
    return (prod > 16'd255) ? 8'hFF : prod[7:0];
  endfunction

  logic [2:0]       key_sync_p0;
  logic [2:0]       key_sync_p1;
  key_state_t       key_state    [3];
  key_state_t       key_state_nx [3];
  logic [CNT_W-1:0] key_cnt      [3];
  logic [CNT_W-1:0] key_cnt_nx   [3];
  logic [2:0]       press_evt;
  logic [2:0]       press_evt_nx;

  logic             p_thresh;
  logic             p_bright;
  logic [LVL_W-1:0] p_level;
  logic [LVL_W-1:0] a_level;
  logic             cfg_differs;

  // Stage p0/p1: two-flop synchronizer. Reset fills it with the idle level.
  always_ff @(posedge clk) begin
    if (reset) begin
      key_sync_p0 <= 3'b111;
      key_sync_p1 <= 3'b111;
    end else begin
      key_sync_p0 <= key_n;
      key_sync_p1 <= key_sync_p0;
    end
  end

  // Debounce stage: one FSM per key. A key released and pressed again
  // inside the wait window is treated as bounce.
  always_comb begin
    for (int i = 0; i < 3; i++) begin
      key_state_nx[i] = key_state[i];
      key_cnt_nx[i]   = key_cnt[i];
      press_evt_nx[i] = 1'b0;
      case (key_state[i])
        RELEASED: begin
          if (!key_sync_p1[i]) begin
            key_cnt_nx[i] = '0;
            if (DEBOUNCE_CYCLES <= 1) begin
              key_state_nx[i] = PRESSED;
              press_evt_nx[i] = 1'b1;
            end else begin
              key_state_nx[i] = PRESS_WAIT;
            end
          end
        end
        PRESS_WAIT: begin
          if (key_sync_p1[i]) begin
            key_state_nx[i] = RELEASED;
            key_cnt_nx[i]   = '0;
          end else if (key_cnt[i] == CNT_LAST) begin
            key_state_nx[i] = PRESSED;
            key_cnt_nx[i]   = '0;
            press_evt_nx[i] = 1'b1;
          end else begin
            key_cnt_nx[i] = key_cnt[i] + 1'b1;
          end
        end
        PRESSED: begin
          if (key_sync_p1[i]) begin
            key_cnt_nx[i]   = '0;
            key_state_nx[i] = (DEBOUNCE_CYCLES <= 1) ? RELEASED : RELEASE_WAIT;
          end
        end
        RELEASE_WAIT: begin
          if (!key_sync_p1[i]) begin
            key_state_nx[i] = PRESSED;
            key_cnt_nx[i]   = '0;
          end else if (key_cnt[i] == CNT_LAST) begin
            key_state_nx[i] = RELEASED;
            key_cnt_nx[i]   = '0;
          end else begin
            key_cnt_nx[i] = key_cnt[i] + 1'b1;
          end
        end
        default: begin
          key_state_nx[i] = RELEASED;
          key_cnt_nx[i]   = '0;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < 3; i++) begin
        key_state[i] <= RELEASED;
        key_cnt[i]   <= '0;
      end
      press_evt <= 3'b000;
    end else begin
      for (int i = 0; i < 3; i++) begin
        key_state[i] <= key_state_nx[i];
        key_cnt[i]   <= key_cnt_nx[i];
      end
      press_evt <= press_evt_nx;
    end
  end

  // Pending stage: press events edit the pending configuration. Events on
  // different keys in the same cycle all take effect.
  always_ff @(posedge clk) begin
    if (reset) begin
      p_thresh <= 1'b0;
      p_bright <= 1'b0;
      p_level  <= LVL_RST;
    end else begin
      if (press_evt[0]) p_thresh <= ~p_thresh;
      if (press_evt[1]) p_bright <= ~p_bright;
      if (press_evt[2]) p_level  <= (p_level == LVL_MAX) ? '0 : p_level + 1'b1;
    end
  end

  assign cfg_differs = (p_thresh != thresh_en) ||
                       (p_bright != bright_en) ||
                       (p_level  != a_level);

  // Active stage: committed at frame_start with the pending values held
  // before this edge. An event landing in the same cycle waits for the
  // next frame.
  always_ff @(posedge clk) begin
    if (reset) begin
      thresh_en     <= 1'b0;
      bright_en     <= 1'b0;
      a_level       <= LVL_RST;
      bright_offset <= sat_offset(LVL_RST);
      cfg_commit    <= 1'b0;
      cfg_dirty     <= 1'b0;
    end else begin
      cfg_commit <= frame_start && cfg_differs;
      cfg_dirty  <= cfg_differs;
      if (frame_start) begin
        thresh_en     <= p_thresh;
        bright_en     <= p_bright;
        a_level       <= p_level;
        bright_offset <= sat_offset(p_level);
      end
    end
  end

endmodule

// File: tb/tb_filter_mode_controller.sv
module tb_filter_mode_controller;

  logic       clk = 1'b0;
  logic       reset;
  logic [2:0] key_n;
  logic       frame_start;
  logic       thresh_en, bright_en, cfg_dirty, cfg_commit;
  logic [7:0] bright_offset;

  logic       reset2;
  logic [2:0] key2_n;
  logic       frame_start2;
  logic       thresh_en2, bright_en2, cfg_dirty2, cfg_commit2;
  logic [7:0] bright_offset2;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  filter_mode_controller #(
    .DEBOUNCE_CYCLES(4), .BRIGHT_LEVELS(4), .BRIGHT_STEP(32), .RESET_LEVEL(1)
  ) dut (
    .clk(clk), .reset(reset), .key_n(key_n), .frame_start(frame_start),
    .thresh_en(thresh_en), .bright_en(bright_en), .bright_offset(bright_offset),
    .cfg_dirty(cfg_dirty), .cfg_commit(cfg_commit)
  );

  filter_mode_controller #(
    .DEBOUNCE_CYCLES(4), .BRIGHT_LEVELS(4), .BRIGHT_STEP(100), .RESET_LEVEL(1)
  ) dut_sat (
    .clk(clk), .reset(reset2), .key_n(key2_n), .frame_start(frame_start2),
    .thresh_en(thresh_en2), .bright_en(bright_en2), .bright_offset(bright_offset2),
    .cfg_dirty(cfg_dirty2), .cfg_commit(cfg_commit2)
  );

  typedef struct {
    logic       rst;
    logic [2:0] kn;
    logic       fs;
    int         n;
    logic       th;
    logic       br;
    logic [7:0] off;
    logic       dirty;
    logic       commit;
  } vec_t;

  vec_t vecs[$];

  task automatic add(input logic rst, input logic [2:0] kn, input logic fs, input int n,
                     input logic th, input logic br, input logic [7:0] off,
                     input logic dirty, input logic commit);
    vec_t v;
    v.rst = rst; v.kn = kn; v.fs = fs; v.n = n;
    v.th = th; v.br = br; v.off = off; v.dirty = dirty; v.commit = commit;
    vecs.push_back(v);
  endtask

  task automatic step(input int n);
    for (int k = 0; k < n; k++) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b1; key_n = 3'b111; frame_start = 1'b0;
    reset2 = 1'b1; key2_n = 3'b111; frame_start2 = 1'b0;

    // reset, then reset mid-PRESS_WAIT with KEY1 held through it
    add(1, 3'b111, 0, 3, 0, 0, 32, 0, 0);
    add(0, 3'b110, 0, 4, 0, 0, 32, 0, 0);
    add(1, 3'b110, 0, 1, 0, 0, 32, 0, 0);
    add(0, 3'b110, 0, 7, 0, 0, 32, 0, 0);
    add(0, 3'b110, 0, 1, 0, 0, 32, 1, 0);
    add(0, 3'b111, 0, 8, 0, 0, 32, 1, 0);
    add(0, 3'b111, 1, 1, 1, 0, 32, 1, 1);
    add(0, 3'b111, 0, 1, 1, 0, 32, 0, 0);
    // bounce on KEY1: low 3, high 1, low 3, high
    add(0, 3'b110, 0, 3, 1, 0, 32, 0, 0);
    add(0, 3'b111, 0, 1, 1, 0, 32, 0, 0);
    add(0, 3'b110, 0, 3, 1, 0, 32, 0, 0);
    add(0, 3'b111, 0, 10, 1, 0, 32, 0, 0);
    // clean KEY2 press held 20 cycles
    add(0, 3'b101, 0, 7, 1, 0, 32, 0, 0);
    add(0, 3'b101, 0, 1, 1, 0, 32, 1, 0);
    add(0, 3'b101, 0, 12, 1, 0, 32, 1, 0);
    add(0, 3'b111, 0, 8, 1, 0, 32, 1, 0);
    add(0, 3'b111, 1, 1, 1, 1, 32, 1, 1);
    add(0, 3'b111, 0, 1, 1, 1, 32, 0, 0);
    // five KEY3 presses: level 1->2->3->0->1->2
    add(0, 3'b011, 0, 8, 1, 1, 32, 1, 0);
    add(0, 3'b111, 0, 8, 1, 1, 32, 1, 0);
    add(0, 3'b011, 0, 8, 1, 1, 32, 1, 0);
    add(0, 3'b111, 0, 8, 1, 1, 32, 1, 0);
    add(0, 3'b011, 0, 8, 1, 1, 32, 1, 0);
    add(0, 3'b111, 0, 8, 1, 1, 32, 1, 0);
    add(0, 3'b011, 0, 8, 1, 1, 32, 0, 0);
    add(0, 3'b111, 0, 8, 1, 1, 32, 0, 0);
    add(0, 3'b011, 0, 8, 1, 1, 32, 1, 0);
    add(0, 3'b111, 0, 8, 1, 1, 32, 1, 0);
    add(0, 3'b111, 1, 1, 1, 1, 64, 1, 1);
    add(0, 3'b111, 0, 1, 1, 1, 64, 0, 0);
    // KEY1 event in the same cycle as frame_start
    add(0, 3'b110, 0, 6, 1, 1, 64, 0, 0);
    add(0, 3'b110, 1, 1, 1, 1, 64, 0, 0);
    add(0, 3'b110, 0, 1, 1, 1, 64, 1, 0);
    add(0, 3'b111, 0, 8, 1, 1, 64, 1, 0);
    add(0, 3'b111, 1, 1, 0, 1, 64, 1, 1);
    add(0, 3'b111, 0, 1, 0, 1, 64, 0, 0);
    // KEY1 twice before a frame: no-op commit
    add(0, 3'b110, 0, 8, 0, 1, 64, 1, 0);
    add(0, 3'b111, 0, 8, 0, 1, 64, 1, 0);
    add(0, 3'b110, 0, 8, 0, 1, 64, 0, 0);
    add(0, 3'b111, 0, 8, 0, 1, 64, 0, 0);
    add(0, 3'b111, 1, 1, 0, 1, 64, 0, 0);
    add(0, 3'b111, 0, 1, 0, 1, 64, 0, 0);
    // KEY1 and KEY2 together
    add(0, 3'b100, 0, 8, 0, 1, 64, 1, 0);
    add(0, 3'b111, 0, 8, 0, 1, 64, 1, 0);
    add(0, 3'b111, 1, 1, 1, 0, 64, 1, 1);
    add(0, 3'b111, 0, 1, 1, 0, 64, 0, 0);

    for (int i = 0; i < vecs.size(); i++) begin
      reset       = vecs[i].rst;
      key_n       = vecs[i].kn;
      frame_start = vecs[i].fs;
      step(vecs[i].n);
      check($sformatf("v%0d thresh_en", i),     {7'd0, thresh_en},  {7'd0, vecs[i].th});
      check($sformatf("v%0d bright_en", i),     {7'd0, bright_en},  {7'd0, vecs[i].br});
      check($sformatf("v%0d bright_offset", i), bright_offset,      vecs[i].off);
      check($sformatf("v%0d cfg_dirty", i),     {7'd0, cfg_dirty},  {7'd0, vecs[i].dirty});
      check($sformatf("v%0d cfg_commit", i),    {7'd0, cfg_commit}, {7'd0, vecs[i].commit});
    end
    reset = 1'b0; key_n = 3'b111; frame_start = 1'b0;

    // saturation: BRIGHT_STEP=100, level 3 -> 300 clamps to 255
    reset2 = 1'b1;
    step(2);
    check("sat reset offset", bright_offset2, 8'd100);
    check("sat reset dirty", {7'd0, cfg_dirty2}, 8'd0);
    reset2 = 1'b0;
    key2_n = 3'b011; step(8);
    key2_n = 3'b111; step(8);
    key2_n = 3'b011; step(8);
    check("sat dirty after presses", {7'd0, cfg_dirty2}, 8'd1);
    check("sat offset before frame", bright_offset2, 8'd100);
    key2_n = 3'b111; step(8);
    frame_start2 = 1'b1; step(1);
    check("sat offset committed", bright_offset2, 8'd255);
    check("sat commit pulse", {7'd0, cfg_commit2}, 8'd1);
    frame_start2 = 1'b0; step(1);
    check("sat commit ends", {7'd0, cfg_commit2}, 8'd0);
    check("sat dirty clears", {7'd0, cfg_dirty2}, 8'd0);
    frame_start2 = 1'b1; step(1);
    check("sat idle frame commit", {7'd0, cfg_commit2}, 8'd0);
    check("sat idle frame offset", bright_offset2, 8'd255);
    frame_start2 = 1'b0; step(1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
